// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the CPU execute stage and data memory: alignment check,
// req/ack DMEM handshake with lane byte enables, load extraction/extension and ack timeout.
module lsu_ctrl #(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        cpu_adel,
    output logic        cpu_ades,
    output logic        cpu_buserr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            we_reg;
    logic            uns_reg;
    logic [1:0]      size_reg;
    logic [1:0]      lane_reg;

    logic            legal;
    logic [3:0]      be_next;
    logic [31:0]     wdata_next;
    logic [31:0]     load_ext;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [7:0]      rd_byte [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    assign cpu_stall = cpu_req & ~cpu_done;

    // Alignment, lane enables and lane-replicated store data for the incoming request
    always_comb begin
        legal      = 1'b0;
        be_next    = 4'b1111;
        wdata_next = cpu_wdata;
        case (cpu_size)
            2'b00: begin
                legal      = 1'b1;
                be_next    = 4'b0001 << cpu_addr[1:0];
                wdata_next = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                legal      = ~cpu_addr[0];
                be_next    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{cpu_wdata[15:0]}};
            end
            2'b10: begin
                legal      = (cpu_addr[1:0] == 2'b00);
            end
            default: begin
                legal      = 1'b0;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        sel_byte = rd_byte[lane_reg];
        sel_half = lane_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_reg)
            2'b00:   load_ext = {{24{sel_byte[7] & ~uns_reg}}, sel_byte};
            2'b01:   load_ext = {{16{sel_half[15] & ~uns_reg}}, sel_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            we_reg     <= 1'b0;
            uns_reg    <= 1'b0;
            size_reg   <= 2'b00;
            lane_reg   <= 2'b00;
            cpu_done   <= 1'b0;
            cpu_rdata  <= '0;
            cpu_adel   <= 1'b0;
            cpu_ades   <= 1'b0;
            cpu_buserr <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu_req) begin
                        if (legal) begin
                            state_reg  <= REQ;
                            cnt_reg    <= '0;
                            we_reg     <= cpu_we;
                            uns_reg    <= cpu_unsigned;
                            size_reg   <= cpu_size;
                            lane_reg   <= cpu_addr[1:0];
                            dmem_req   <= 1'b1;
                            dmem_we    <= cpu_we;
                            dmem_addr  <= {cpu_addr[31:2], 2'b00};
                            dmem_be    <= be_next;
                            dmem_wdata <= wdata_next;
                        end else begin
                            state_reg  <= ERR;
                            cpu_done   <= 1'b1;
                            cpu_adel   <= ~cpu_we;
                            cpu_ades   <= cpu_we;
                        end
                    end
                end
                REQ: begin
                    // An ack in the expiry cycle takes priority over the timeout
                    if (dmem_ack || cnt_reg == CNT_LAST) begin
                        state_reg <= DONE;
                        cpu_done  <= 1'b1;
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        dmem_be   <= '0;
                        if (dmem_ack) begin
                            if (!we_reg) begin
                                cpu_rdata <= load_ext;
                            end
                        end else begin
                            cpu_buserr <= 1'b1;
                            cpu_rdata  <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg  <= IDLE;
                    cpu_done   <= 1'b0;
                    cpu_buserr <= 1'b0;
                    cnt_reg    <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    cpu_done  <= 1'b0;
                    cpu_adel  <= 1'b0;
                    cpu_ades  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: each access pushes its expected outcome, which is popped
// and compared when cpu_done fires; a small DMEM responder acks after a programmed wait.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_unsigned = 1'b0;
    logic [1:0]  cpu_size = 2'b00;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_stall, cpu_done, cpu_adel, cpu_ades, cpu_buserr;
    logic [31:0] cpu_rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic        we;
        logic [2:0]  err;    // {adel, ades, buserr}
        int          lat;
        int          reqc;
        int          stall;
    } exp_t;

    exp_t sb_q[$];

    lsu_ctrl #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cpu_adel(cpu_adel), .cpu_ades(cpu_ades), .cpu_buserr(cpu_buserr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // waits: REQ cycles without ack before acking (255 = never ack)
    task automatic do_acc(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] mem, input int waits, input exp_t e);
        int n, reqc, stallc, lat;
        logic [31:0] c_be, c_wdata, c_addr;
        logic c_we;
        exp_t got;
        bit done_seen;
        n = 0; reqc = 0; stallc = 0; lat = -1; done_seen = 0;
        c_be = '0; c_wdata = '0; c_addr = '0; c_we = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
        cpu_addr = addr; cpu_wdata = wdata;
        sb_q.push_back(e);
        #1;
        if (cpu_stall) stallc++;
        while (!done_seen && n < 300) begin
            @(negedge clk);
            n++;
            if (cpu_stall) stallc++;
            if (dmem_req) begin
                reqc++;
                if (reqc == 1) begin
                    c_be = {28'd0, dmem_be}; c_wdata = dmem_wdata;
                    c_addr = dmem_addr; c_we = dmem_we;
                end
            end
            if (cpu_done) begin
                done_seen = 1;
                lat = n;
                got.rdata = cpu_rdata;
                got.err = {cpu_adel, cpu_ades, cpu_buserr};
                dmem_ack = 1'b0;
                cpu_req = 1'b0;
            end else begin
                dmem_ack   = dmem_req && (reqc > waits);
                dmem_rdata = mem;
            end
        end
        chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_lat"},   32'(lat),    32'(e.lat));
            chk({tag, "_rdata"}, got.rdata,   e.rdata);
            chk({tag, "_err"},   32'(got.err), 32'(e.err));
            chk({tag, "_reqc"},  32'(reqc),   32'(e.reqc));
            chk({tag, "_stall"}, 32'(stallc), 32'(e.stall));
            chk({tag, "_be"},    c_be,        e.be);
            chk({tag, "_wdata"}, c_wdata,     e.wdata);
            chk({tag, "_addr"},  c_addr,      e.addr);
            chk({tag, "_we"},    32'(c_we),   32'(e.we));
        end
        @(negedge clk);
        chk({tag, "_pulse"}, 32'({cpu_done, cpu_buserr, cpu_adel, cpu_ades}), 32'd0);
        $display("txn %s lat=%0d reqc=%0d rdata=%h be=%h err=%b", tag, lat, reqc,
                 got.rdata, c_be[3:0], got.err);
    endtask

    function automatic exp_t mk(input logic [31:0] rdata, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] addr,
                                input logic we, input logic [2:0] err,
                                input int lat, input int reqc, input int stall);
        exp_t e;
        e.rdata = rdata; e.be = {28'd0, be}; e.wdata = wdata; e.addr = addr; e.we = we;
        e.err = err; e.lat = lat; e.reqc = reqc; e.stall = stall;
        return e;
    endfunction

    initial begin
        rst = 1'b1;
        #1;
        chk("rst_outputs", {cpu_rdata[31:4] | dmem_addr[31:4] | dmem_wdata[31:4],
                            cpu_done, dmem_req, dmem_we, cpu_adel | cpu_ades | cpu_buserr}, 32'd0);
        chk("rst_be", {28'd0, dmem_be}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // lb / lbu at 0x1003, ack in first REQ cycle
        do_acc("lb",  0, 2'b00, 0, 32'h1003, 32'h0, 32'h80FF_1234, 0,
               mk(32'hFFFF_FF80, 4'b1000, 32'h0, 32'h1000, 0, 3'b000, 2, 1, 2));
        do_acc("lbu", 0, 2'b00, 1, 32'h1003, 32'h0, 32'h80FF_1234, 0,
               mk(32'h0000_0080, 4'b1000, 32'h0, 32'h1000, 0, 3'b000, 2, 1, 2));
        // lh with three wait cycles
        do_acc("lh",  0, 2'b01, 0, 32'h2002, 32'h0, 32'h9ABC_0000, 3,
               mk(32'hFFFF_9ABC, 4'b1100, 32'h0, 32'h2000, 0, 3'b000, 5, 4, 5));
        // sb: replicated data, rdata unchanged
        do_acc("sb",  1, 2'b00, 0, 32'h0001, 32'h0000_00A5, 32'hDEAD_BEEF, 0,
               mk(32'hFFFF_9ABC, 4'b0010, 32'hA5A5_A5A5, 32'h0000, 1, 3'b000, 2, 1, 2));
        // misaligned lw / sh
        do_acc("lw_mis", 0, 2'b10, 0, 32'h0006, 32'h0, 32'h1111_1111, 0,
               mk(32'hFFFF_9ABC, 4'b0000, 32'h0, 32'h0, 0, 3'b100, 1, 0, 1));
        do_acc("sh_mis", 1, 2'b01, 0, 32'h0003, 32'h1234, 32'h1111_1111, 0,
               mk(32'hFFFF_9ABC, 4'b0000, 32'h0, 32'h0, 0, 3'b010, 1, 0, 1));
        // timeout, then ack in the expiry cycle
        do_acc("lw_to", 0, 2'b10, 0, 32'h0010, 32'h0, 32'h5555_5555, 255,
               mk(32'h0, 4'b1111, 32'h0, 32'h0010, 0, 3'b001, 5, 4, 5));
        do_acc("lw_ack4", 0, 2'b10, 0, 32'h0010, 32'h0, 32'h1234_5678, 3,
               mk(32'h1234_5678, 4'b1111, 32'h0, 32'h0010, 0, 3'b000, 5, 4, 5));
        // further lanes and extension cases
        do_acc("lhu", 0, 2'b01, 1, 32'h0002, 32'h0, 32'h8001_0000, 0,
               mk(32'h0000_8001, 4'b1100, 32'h0, 32'h0, 0, 3'b000, 2, 1, 2));
        do_acc("lh0", 0, 2'b01, 0, 32'h0000, 32'h0, 32'h0000_8001, 0,
               mk(32'hFFFF_8001, 4'b0011, 32'h0, 32'h0, 0, 3'b000, 2, 1, 2));
        do_acc("sh",  1, 2'b01, 0, 32'h0002, 32'h0000_BEEF, 32'h0, 0,
               mk(32'hFFFF_8001, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1, 3'b000, 2, 1, 2));
        do_acc("lb0", 0, 2'b00, 0, 32'h0000, 32'h0, 32'hFFFF_FF7F, 1,
               mk(32'h0000_007F, 4'b0001, 32'h0, 32'h0, 0, 3'b000, 3, 2, 3));
        do_acc("sz11", 0, 2'b11, 0, 32'h0000, 32'h0, 32'h0, 0,
               mk(32'h0000_007F, 4'b0000, 32'h0, 32'h0, 0, 3'b100, 1, 0, 1));

        // asynchronous reset in the middle of a REQ wait
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h0010;
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_req_active", 32'(dmem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_req", 32'({dmem_req, dmem_we, cpu_done}), 32'd0);
        chk("rst_async_rdata", cpu_rdata, 32'd0);
        chk("rst_async_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_async_addr", dmem_addr, 32'd0);
        @(negedge clk);
        cpu_req = 1'b0;
        rst = 1'b0;
        $display("txn reset_mid_req dmem_req=%b rdata=%h", dmem_req, cpu_rdata);

        do_acc("sw",  1, 2'b10, 0, 32'h0004, 32'hCAFE_F00D, 32'h0, 0,
               mk(32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0004, 1, 3'b000, 2, 1, 2));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multicycle load/store sequencer between the CPU54 execute stage and the data memory (DMEM).
- Accepts one sub-word or word access from the CPU, checks alignment, and drives a req/ack handshake to DMEM with per-lane byte enables.
- On loads, extracts the addressed byte or halfword and sign- or zero-extends it.
- Holds the pipeline stalled until the access completes, faults or times out.

Parameters:
- ACK_TIMEOUT, default 64, maximum REQ-state cycles waiting for dmem_ack before a bus error is raised (legal range 2..256).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- cpu_req  in  1  access request, held by the CPU while cpu_stall=1
- cpu_we  in  1  1=store, 0=load
- cpu_size  in  2  00=byte, 01=half, 10=word, 11=reserved
- cpu_unsigned  in  1  load zero-extends when 1 (lbu/lhu), sign-extends when 0 (lb/lh)
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, right-justified
- cpu_stall  out  1  combinational: cpu_req & ~cpu_done
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  32  extended load result, registered
- cpu_adel  out  1  load address error, pulses with cpu_done
- cpu_ades  out  1  store address error, pulses with cpu_done
- cpu_buserr  out  1  DMEM ack timeout, pulses with cpu_done
- dmem_req  out  1  DMEM request, registered
- dmem_we  out  1  DMEM write strobe
- dmem_addr  out  32  {cpu_addr[31:2],2'b00}
- dmem_be  out  4  byte enables, little-endian lanes
- dmem_wdata  out  32  store data replicated into the addressed lane(s)
- dmem_ack  in  1  DMEM completion; dmem_rdata is valid in the same cycle
- dmem_rdata  in  32  DMEM read word

Behaviour:
- Reset (async, immediate) values:
  - State = IDLE.
  - All outputs 0, including cpu_rdata.
  - Timeout counter 0.
  - dmem_req drops without waiting for a clock.
- States: IDLE, REQ, DONE, ERR.
- IDLE, on cpu_req=1, evaluates alignment:
  - Byte: always legal.
  - Half: requires addr[0]=0.
  - Word: requires addr[1:0]=0.
  - Size 11: always illegal.
- IDLE, legal access:
  - Register we, size, unsigned, addr[1:0] and aligned address.
  - Compute be and wdata, then go to REQ.
- IDLE, illegal access:
  - Go to ERR; no DMEM cycle is issued.
- Byte enables:
  - Byte: be = 0001 << addr[1:0].
  - Half: be = 0011 or 1100, selected by addr[1].
  - Word: be = 1111.
- Store data: byte replicated x4, half replicated x2, word passed through unchanged.
- REQ:
  - dmem_req=1, with dmem_we/addr/be/wdata stable for the whole state.
  - On dmem_ack=1: for loads, capture the extracted and extended dmem_rdata into cpu_rdata; go to DONE; dmem_req=0 next cycle.
  - Without ack: increment the counter.
  - When the counter reaches ACK_TIMEOUT-1 with no ack: go to DONE with a buserr flag; cpu_rdata=0.
  - An ack arriving in the expiry cycle wins over the timeout.
- Load extraction: lane = addr[1:0] (byte) or addr[1] (half). Sign bit is bit 7 (byte) or bit 15 (half) of the selected lane, unless unsigned=1.
- Word loads return dmem_rdata unchanged; cpu_rdata is not updated on stores.
- DONE: cpu_done=1 for one cycle; cpu_buserr=flag; then go to IDLE, clear the counter and the flag.
- ERR: cpu_done=1 with cpu_adel (load) or cpu_ades (store) for one cycle; then go to IDLE.
- cpu_rdata holds its value until the next load completion, buserr or reset.
- Latency: IDLE-accept to cpu_done = 2 cycles with zero-wait ack; add one cycle per wait cycle; ERR path is 1 cycle.
- Request sampling:
  - cpu_req is sampled only in IDLE; changes to CPU inputs during REQ, DONE or ERR are ignored.
  - A cpu_req still high in the IDLE cycle after DONE starts a new access.
- dmem_ack in IDLE, DONE or ERR is ignored.

Test Plan:
- lb at addr 0x1003, dmem_rdata=0x80FF_1234, ack in first REQ cycle -> dmem_be=1000, cpu_done at cycle 2, cpu_rdata=0xFFFF_FF80; same access as lbu -> 0x0000_0080.
- lh at 0x2002, dmem_rdata=0x9ABC_0000, ack after 3 wait cycles -> dmem_be=1100, cpu_rdata=0xFFFF_9ABC, cpu_stall high for 5 cycles, cpu_done at cycle 5.
- sb at 0x0001, wdata=0x0000_00A5 -> dmem_we=1, dmem_be=0010, dmem_wdata=0xA5A5_A5A5, dmem_addr=0x0000_0000, cpu_rdata unchanged.
- lw at 0x0006 -> no dmem_req ever asserted, cpu_adel=1 and cpu_done=1 one cycle after request; sh at 0x0003 -> cpu_ades=1.
- lw at 0x0010, ACK_TIMEOUT=4, ack never asserted -> dmem_req high exactly 4 cycles, then cpu_done=1 with cpu_buserr=1 and cpu_rdata=0; repeat with ack in the 4th cycle -> normal completion, no buserr.
- Assert rst mid-REQ -> dmem_req=0 and all outputs 0 immediately; after release, a new sw at 0x0004 completes normally with dmem_be=1111.
